fc_tx_controller_top: RTL and testbench
=======================================

Name: fc_tx_controller_top

Overview:
- Transmit-side PCIe flow-control credit gate for three credit classes: Posted (P), Non-Posted (NP) and Completion (Cpl).
- Holds per-class credit limits (CL), loaded by InitFC and raised by UpdateFC DLLPs from the receive path.
- Holds per-class credits consumed (CC) and grants a TLP send request only when enough header and data credit remain.
- Sits between the TLP arbiter and the DLLP receive decoder.

Parameters:
- HDR_W, 8, header credit field width (modulo 2^8 arithmetic)
- DATA_W, 12, data credit field width (modulo 2^12 arithmetic)
- SIZE_W, 8, send_tlp_size_i width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- hdr_credit_i  in  HDR_W  header credit value carried by the DLLP
- data_credit_i  in  DATA_W  data credit value carried by the DLLP
- is_initFC_i  in  1  InitFC DLLP qualifier
- is_updateFC_i  in  1  UpdateFC DLLP qualifier
- type_credit_i  in  2  DLLP credit class: 00=P, 01=NP, 10=Cpl, 11=none
- send_tlp_req_i  in  1  TLP send request
- send_tlp_type_i  in  2  TLP credit class, same encoding as type_credit_i
- send_tlp_size_i  in  SIZE_W  TLP payload size in data-credit units; 0 = no payload
- send_tlp_grant_o  out  1  registered grant pulse

Behaviour:
- State per class c in {P, NP, Cpl}:
  - cl_hdr[c] (HDR_W), cl_data[c] (DATA_W)
  - cc_hdr[c] (HDR_W), cc_data[c] (DATA_W)
  - Named exactly so, as arrays indexed by class, for bench hierarchical access.
- Reset: all CL, CC and send_tlp_grant_o = 0. Reset mid-operation clears everything on that edge.
- Credit update, per clock edge, when type_credit_i != 11:
  - is_initFC_i=1: cl_hdr[t] <= hdr_credit_i, cl_data[t] <= data_credit_i (overwrite; re-applying the same values is idempotent).
  - else if is_updateFC_i=1: cl_hdr[t] += hdr_credit_i, cl_data[t] += data_credit_i, modulo 2^width. Additive each cycle; a cycle with value 0 leaves CL unchanged.
  - Both flags high: InitFC wins.
  - type_credit_i=11, or both flags low: no CL change.
- Combinational required credit:
  - required_hdr_credit = 1
  - required_data_credit = send_tlp_size_i, zero-extended to DATA_W
- gating_pass (combinational) is 1 when send_tlp_type_i != 11 and, for class t:
  - (cl_hdr[t] - (cc_hdr[t] + required_hdr_credit)) mod 2^HDR_W <= 2^(HDR_W-1), and
  - (cl_data[t] - (cc_data[t] + required_data_credit)) mod 2^DATA_W <= 2^(DATA_W-1).
- Grant: at each edge, send_tlp_grant_o <= send_tlp_req_i & gating_pass.
  - When that value is 1, cc_hdr[t] and cc_data[t] are incremented by the required amounts in the same edge.
  - Latency is 1 cycle from request to grant.
  - A request held high is re-evaluated and consumes credit every cycle. The requester must drop send_tlp_req_i after one cycle per TLP.
- A denied request has no side effects. Grant is 0 whenever send_tlp_req_i was 0.
- CL update and CC consumption on the same class in the same cycle both take effect. Gating uses the pre-edge CL.
- CC and CL wrap modulo 2^width; the gating formula tolerates the wrap.

Optional Feature:
- Macro: FC_INFINITE_CREDIT_EN.
- Defined:
  - Per class and field, an InitFC value of 0 sets an "infinite" flag.
  - That field's check is then always passed.
  - The flag is cleared by reset or by a non-zero InitFC.
  - UpdateFC does not change the flag.
- Undefined: 0 is an ordinary limit, and a class initialised to 0 is never granted.

Decomposition:
- Package fc_pkg:
  - enum fc_type_t: FC_P=2'b00, FC_NP=2'b01, FC_CPL=2'b10, FC_NONE=2'b11
  - HDR_W and DATA_W constants
  - FC_NUM_TYPES=3
- One sub-module, fc_credit_tracker:
  - Holds CL/CC and the gating compare for a single class.
  - Instantiated 3 times.
  - Top handles decode, muxing and the grant register.

Test Plan:
- Reset, then InitFC P=7/10, NP=8/11, Cpl=9/12 -> cl_hdr/cl_data match; all CC 0; grant 0.
- P requests, sizes 1,2,3,4 -> each granted 1 cycle later; cc_hdr[P]=4, cc_data[P]=10. Next request size 5 -> no grant, CC unchanged.
- UpdateFC P with 10/50 for one cycle, then 0/0 -> cl_hdr[P]=17, cl_data[P]=60. Size 5 request -> granted; cc_data[P]=15.
- Ten NP requests, size 0 -> first 8 granted; cc_hdr[NP]=8; requests 9 and 10 denied; cc_data[NP]=0.
- Cpl requests, sizes 1..10 -> sizes 1..4 granted (cc_data=10 ≤ 12), size 5 denied, sizes 6..10 denied. UpdateFC Cpl +10/+50 -> cl 19/62; next size 5 granted.
- send_tlp_type_i=11 with req, or req held 2 cycles with ample credit -> no grant for type 11; 2 grants and double CC for held req. Reset asserted mid-sequence -> all state 0.

Source files
------------

// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Shared types and constants for the transmit-side flow-control credit gate.
//   fc_type_t    : credit class encoding used by both DLLP and TLP sides
//   HDR_W/DATA_W : header / data credit field widths (modulo arithmetic)
//   SIZE_W       : width of the TLP payload size request
//   FC_NUM_TYPES : number of real credit classes (P, NP, Cpl)
// Helper functions implement the wrap-tolerant "enough credit left" test.
// ---------------------------------------------------------------------------
package fc_pkg;

    typedef enum logic [1:0] {
        FC_P    = 2'b00,
        FC_NP   = 2'b01,
        FC_CPL  = 2'b10,
        FC_NONE = 2'b11
    } fc_type_t;

    localparam int HDR_W        = 8;
    localparam int DATA_W       = 12;
    localparam int SIZE_W       = 8;
    localparam int FC_NUM_TYPES = 3;

    localparam logic [HDR_W-1:0]  HDR_HALF  = HDR_W'(1 << (HDR_W - 1));
    localparam logic [DATA_W-1:0] DATA_HALF = DATA_W'(1 << (DATA_W - 1));

    // Remaining credit after this TLP, taken modulo the field width, must land
    // in the lower half of the number circle; this survives CL/CC wrap.
    function automatic logic hdr_fits(input logic [HDR_W-1:0] cl,
                                      input logic [HDR_W-1:0] cc,
                                      input logic [HDR_W-1:0] need);
        logic [HDR_W-1:0] rem;
        rem = cl - (cc + need);
        return (rem <= HDR_HALF);
    endfunction

    function automatic logic data_fits(input logic [DATA_W-1:0] cl,
                                       input logic [DATA_W-1:0] cc,
                                       input logic [DATA_W-1:0] need);
        logic [DATA_W-1:0] rem;
        rem = cl - (cc + need);
        return (rem <= DATA_HALF);
    endfunction

endpackage

// File: rtl/fc_tx_controller_top_tracker.sv
// ---------------------------------------------------------------------------
// fc_credit_tracker
// Credit limit (CL) / credits consumed (CC) bookkeeping and gating compare
// for a single flow-control class.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   init_i          : InitFC for this class (overwrites CL)
//   update_i        : UpdateFC for this class (adds to CL), already masked by init
//   hdr_credit_i    : DLLP header credit value
//   data_credit_i   : DLLP data credit value
//   consume_i       : a grant for this class is issued on this edge
//   req_data_i      : data credits needed by the pending TLP
//   pass_o          : enough header and data credit for the pending TLP
//   cl_*_o, cc_*_o  : current CL / CC values
// Optional macro FC_INFINITE_CREDIT_EN: an InitFC value of 0 marks that field
// as infinite so its check always passes.
// ---------------------------------------------------------------------------
module fc_credit_tracker
    import fc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              update_i,
    input  logic [HDR_W-1:0]  hdr_credit_i,
    input  logic [DATA_W-1:0] data_credit_i,
    input  logic              consume_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              pass_o,
    output logic [HDR_W-1:0]  cl_hdr_o,
    output logic [DATA_W-1:0] cl_data_o,
    output logic [HDR_W-1:0]  cc_hdr_o,
    output logic [DATA_W-1:0] cc_data_o
);

    logic [HDR_W-1:0]  cl_hdr_q,  cl_hdr_d;
    logic [DATA_W-1:0] cl_data_q, cl_data_d;
    logic [HDR_W-1:0]  cc_hdr_q,  cc_hdr_d;
    logic [DATA_W-1:0] cc_data_q, cc_data_d;
    logic              hdr_ok;
    logic              data_ok;

`ifdef FC_INFINITE_CREDIT_EN
    logic inf_hdr_q,  inf_hdr_d;
    logic inf_data_q, inf_data_d;
`endif

    // Next-state: CL loads or accumulates from DLLPs, CC advances on grant.
    // Both may happen in the same cycle; the gate below sees pre-edge values.
    always_comb begin
        cl_hdr_d  = cl_hdr_q;
        cl_data_d = cl_data_q;
        cc_hdr_d  = cc_hdr_q;
        cc_data_d = cc_data_q;
        if (init_i) begin
            cl_hdr_d  = hdr_credit_i;
            cl_data_d = data_credit_i;
        end else if (update_i) begin
            cl_hdr_d  = cl_hdr_q + hdr_credit_i;
            cl_data_d = cl_data_q + data_credit_i;
        end
        if (consume_i) begin
            cc_hdr_d  = cc_hdr_q + HDR_W'(1);
            cc_data_d = cc_data_q + req_data_i;
        end
    end

`ifdef FC_INFINITE_CREDIT_EN
    // Infinite flags follow InitFC only; UpdateFC leaves them alone.
    always_comb begin
        inf_hdr_d  = inf_hdr_q;
        inf_data_d = inf_data_q;
        if (init_i) begin
            inf_hdr_d  = (hdr_credit_i == '0);
            inf_data_d = (data_credit_i == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inf_hdr_q  <= 1'b0;
            inf_data_q <= 1'b0;
        end else begin
            inf_hdr_q  <= inf_hdr_d;
            inf_data_q <= inf_data_d;
        end
    end

    // Gating compare, with infinite fields always passing.
    always_comb begin
        hdr_ok  = inf_hdr_q  | hdr_fits(cl_hdr_q, cc_hdr_q, HDR_W'(1));
        data_ok = inf_data_q | data_fits(cl_data_q, cc_data_q, req_data_i);
    end
`else
    // Gating compare; a limit of 0 is an ordinary (empty) limit.
    always_comb begin
        hdr_ok  = hdr_fits(cl_hdr_q, cc_hdr_q, HDR_W'(1));
        data_ok = data_fits(cl_data_q, cc_data_q, req_data_i);
    end
`endif

    // Credit state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cl_hdr_q  <= '0;
            cl_data_q <= '0;
            cc_hdr_q  <= '0;
            cc_data_q <= '0;
        end else begin
            cl_hdr_q  <= cl_hdr_d;
            cl_data_q <= cl_data_d;
            cc_hdr_q  <= cc_hdr_d;
            cc_data_q <= cc_data_d;
        end
    end

    assign pass_o    = hdr_ok & data_ok;
    assign cl_hdr_o  = cl_hdr_q;
    assign cl_data_o = cl_data_q;
    assign cc_hdr_o  = cc_hdr_q;
    assign cc_data_o = cc_data_q;

endmodule

// File: rtl/fc_tx_controller_top.sv
// ---------------------------------------------------------------------------
// fc_tx_controller_top
// Transmit-side PCIe flow-control credit gate for P, NP and Cpl classes.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   hdr_credit_i      : DLLP header credit value
//   data_credit_i     : DLLP data credit value
//   is_initFC_i       : InitFC qualifier (wins over UpdateFC)
//   is_updateFC_i     : UpdateFC qualifier
//   type_credit_i     : DLLP class, 00=P 01=NP 10=Cpl 11=none
//   send_tlp_req_i    : TLP send request (one cycle per TLP)
//   send_tlp_type_i   : TLP class, same encoding
//   send_tlp_size_i   : TLP payload in data-credit units
//   send_tlp_grant_o  : registered grant, one cycle after the request
// Optional macro FC_INFINITE_CREDIT_EN (see fc_credit_tracker).
// Per-class state is exposed as cl_hdr/cl_data/cc_hdr/cc_data arrays.
// ---------------------------------------------------------------------------
module fc_tx_controller_top
    import fc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [HDR_W-1:0]  hdr_credit_i,
    input  logic [DATA_W-1:0] data_credit_i,
    input  logic              is_initFC_i,
    input  logic              is_updateFC_i,
    input  logic [1:0]        type_credit_i,
    input  logic              send_tlp_req_i,
    input  logic [1:0]        send_tlp_type_i,
    input  logic [SIZE_W-1:0] send_tlp_size_i,
    output logic              send_tlp_grant_o
);

    logic [HDR_W-1:0]        cl_hdr  [FC_NUM_TYPES];
    logic [DATA_W-1:0]       cl_data [FC_NUM_TYPES];
    logic [HDR_W-1:0]        cc_hdr  [FC_NUM_TYPES];
    logic [DATA_W-1:0]       cc_data [FC_NUM_TYPES];

    logic [FC_NUM_TYPES-1:0] init_vec;
    logic [FC_NUM_TYPES-1:0] update_vec;
    logic [FC_NUM_TYPES-1:0] consume_vec;
    logic [FC_NUM_TYPES-1:0] pass_vec;
    logic [DATA_W-1:0]       required_data_credit;
    logic                    gating_pass;
    logic                    send_tlp_grant_d, send_tlp_grant_q;

    assign required_data_credit = DATA_W'(send_tlp_size_i);

    // Decode DLLP and grant strobes per class, and select the gate result of
    // the requested class; class 11 never passes.
    always_comb begin
        init_vec    = '0;
        update_vec  = '0;
        consume_vec = '0;
        gating_pass = 1'b0;
        case (fc_type_t'(send_tlp_type_i))
            FC_P:    gating_pass = pass_vec[0];
            FC_NP:   gating_pass = pass_vec[1];
            FC_CPL:  gating_pass = pass_vec[2];
            default: gating_pass = 1'b0;
        endcase
        send_tlp_grant_d = send_tlp_req_i & gating_pass;
        for (int i = 0; i < FC_NUM_TYPES; i++) begin
            init_vec[i]    = is_initFC_i && (type_credit_i == 2'(i));
            update_vec[i]  = !is_initFC_i && is_updateFC_i && (type_credit_i == 2'(i));
            consume_vec[i] = send_tlp_grant_d && (send_tlp_type_i == 2'(i));
        end
    end

    for (genvar g = 0; g < FC_NUM_TYPES; g++) begin : g_class
        fc_credit_tracker u_tracker (
            .clk           (clk),
            .rst           (rst),
            .init_i        (init_vec[g]),
            .update_i      (update_vec[g]),
            .hdr_credit_i  (hdr_credit_i),
            .data_credit_i (data_credit_i),
            .consume_i     (consume_vec[g]),
            .req_data_i    (required_data_credit),
            .pass_o        (pass_vec[g]),
            .cl_hdr_o      (cl_hdr[g]),
            .cl_data_o     (cl_data[g]),
            .cc_hdr_o      (cc_hdr[g]),
            .cc_data_o     (cc_data[g])
        );
    end

    // Grant register.
    always_ff @(posedge clk) begin
        if (rst) begin
            send_tlp_grant_q <= 1'b0;
        end else begin
            send_tlp_grant_q <= send_tlp_grant_d;
        end
    end

    assign send_tlp_grant_o = send_tlp_grant_q;

endmodule

// File: tb/tb_fc_tx_controller_top.sv
// ---------------------------------------------------------------------------
// tb_fc_tx_controller_top
// Directed stimulus against fc_tx_controller_top with a credit-accounting
// model that is compared against the DUT on every cycle, plus literal
// expectations at key points of the sequence.
// ---------------------------------------------------------------------------
module tb_fc_tx_controller_top;
    import fc_pkg::*;

    logic              clk;
    logic              rst;
    logic [HDR_W-1:0]  hdr_credit_i;
    logic [DATA_W-1:0] data_credit_i;
    logic              is_initFC_i;
    logic              is_updateFC_i;
    logic [1:0]        type_credit_i;
    logic              send_tlp_req_i;
    logic [1:0]        send_tlp_type_i;
    logic [SIZE_W-1:0] send_tlp_size_i;
    logic              send_tlp_grant_o;

    int checks;
    int failures;

    // Model state: plain integers kept inside the field ranges.
    int m_cl_hdr [3];
    int m_cl_data[3];
    int m_cc_hdr [3];
    int m_cc_data[3];
    int m_inf_hdr[3];
    int m_inf_data[3];
    bit m_grant;
    bit model_valid;

    fc_tx_controller_top dut (
        .clk              (clk),
        .rst              (rst),
        .hdr_credit_i     (hdr_credit_i),
        .data_credit_i    (data_credit_i),
        .is_initFC_i      (is_initFC_i),
        .is_updateFC_i    (is_updateFC_i),
        .type_credit_i    (type_credit_i),
        .send_tlp_req_i   (send_tlp_req_i),
        .send_tlp_type_i  (send_tlp_type_i),
        .send_tlp_size_i  (send_tlp_size_i),
        .send_tlp_grant_o (send_tlp_grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record one comparison and report it if it disagrees.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let one edge pass, then return to idle.
    task automatic applyStimulus(input bit init, input bit upd, input int ctype,
                                 input int hcr, input int dcr,
                                 input bit req, input int rtype, input int size);
        is_initFC_i     = init;
        is_updateFC_i   = upd;
        type_credit_i   = 2'(ctype);
        hdr_credit_i    = HDR_W'(hcr);
        data_credit_i   = DATA_W'(dcr);
        send_tlp_req_i  = req;
        send_tlp_type_i = 2'(rtype);
        send_tlp_size_i = SIZE_W'(size);
        @(posedge clk);
        #1;
        is_initFC_i     = 1'b0;
        is_updateFC_i   = 1'b0;
        type_credit_i   = 2'b11;
        hdr_credit_i    = '0;
        data_credit_i   = '0;
        send_tlp_req_i  = 1'b0;
        send_tlp_type_i = 2'b11;
        send_tlp_size_i = '0;
    endtask

    task automatic sendTlp(input int rtype, input int size, input bit expect_grant, input string name);
        applyStimulus(0, 0, 3, 0, 0, 1, rtype, size);
        checkOutput(name, int'(send_tlp_grant_o), int'(expect_grant));
    endtask

    // Credit accounting model: a TLP fits when the credits left after it,
    // counted on the modulo circle, are no more than half the range.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cl_hdr[i] = 0; m_cl_data[i] = 0;
                m_cc_hdr[i] = 0; m_cc_data[i] = 0;
                m_inf_hdr[i] = 0; m_inf_data[i] = 0;
            end
            m_grant     = 0;
            model_valid = 1;
        end else begin
            int  t;
            int  left_h;
            int  left_d;
            bit  ok;
            ok = 0;
            t  = int'(send_tlp_type_i);
            if (t != 3) begin
                left_h = (m_cl_hdr[t] - m_cc_hdr[t] - 1) & 255;
                left_d = (m_cl_data[t] - m_cc_data[t] - int'(send_tlp_size_i)) & 4095;
                ok = (left_h <= 128 || m_inf_hdr[t] != 0) && (left_d <= 2048 || m_inf_data[t] != 0);
            end
            m_grant = send_tlp_req_i && ok;
            if (type_credit_i != 2'b11) begin
                int c;
                c = int'(type_credit_i);
                if (is_initFC_i) begin
                    m_cl_hdr[c]  = int'(hdr_credit_i);
                    m_cl_data[c] = int'(data_credit_i);
`ifdef FC_INFINITE_CREDIT_EN
                    m_inf_hdr[c]  = (hdr_credit_i == 0) ? 1 : 0;
                    m_inf_data[c] = (data_credit_i == 0) ? 1 : 0;
`endif
                end else if (is_updateFC_i) begin
                    m_cl_hdr[c]  = (m_cl_hdr[c] + int'(hdr_credit_i)) & 255;
                    m_cl_data[c] = (m_cl_data[c] + int'(data_credit_i)) & 4095;
                end
            end
            if (m_grant) begin
                m_cc_hdr[t]  = (m_cc_hdr[t] + 1) & 255;
                m_cc_data[t] = (m_cc_data[t] + int'(send_tlp_size_i)) & 4095;
            end
        end
    end

    // Cycle-by-cycle compare of grant and all credit state against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("grant_vs_model", int'(send_tlp_grant_o), int'(m_grant));
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("cl_hdr[%0d]_vs_model", i), int'(dut.cl_hdr[i]), m_cl_hdr[i]);
                checkOutput($sformatf("cl_data[%0d]_vs_model", i), int'(dut.cl_data[i]), m_cl_data[i]);
                checkOutput($sformatf("cc_hdr[%0d]_vs_model", i), int'(dut.cc_hdr[i]), m_cc_hdr[i]);
                checkOutput($sformatf("cc_data[%0d]_vs_model", i), int'(dut.cc_data[i]), m_cc_data[i]);
            end
        end
    end

    // Directed sequence with hand-computed literal expectations.
    initial begin
        checks          = 0;
        failures        = 0;
        model_valid     = 0;
        rst             = 1'b1;
        is_initFC_i     = 1'b0;
        is_updateFC_i   = 1'b0;
        type_credit_i   = 2'b11;
        hdr_credit_i    = '0;
        data_credit_i   = '0;
        send_tlp_req_i  = 1'b0;
        send_tlp_type_i = 2'b11;
        send_tlp_size_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        checkOutput("reset_grant", int'(send_tlp_grant_o), 0);
        checkOutput("reset_cl_hdr_p", int'(dut.cl_hdr[0]), 0);
        checkOutput("reset_cc_data_cpl", int'(dut.cc_data[2]), 0);

        // Zero limit after reset is never granted, even without payload.
        sendTlp(0, 0, 0, "zero_limit_deny");

        // InitFC for all three classes.
        applyStimulus(1, 0, 0, 7, 10, 0, 3, 0);
        applyStimulus(1, 0, 1, 8, 11, 0, 3, 0);
        applyStimulus(1, 0, 2, 9, 12, 0, 3, 0);
        checkOutput("init_cl_hdr_p", int'(dut.cl_hdr[0]), 7);
        checkOutput("init_cl_data_np", int'(dut.cl_data[1]), 11);
        checkOutput("init_cl_hdr_cpl", int'(dut.cl_hdr[2]), 9);
        checkOutput("init_cl_data_cpl", int'(dut.cl_data[2]), 12);
        applyStimulus(1, 0, 0, 7, 10, 0, 3, 0);
        checkOutput("init_idempotent", int'(dut.cl_data[0]), 10);

        // Posted: sizes 1..4 fill data credit exactly, size 5 is refused.
        for (int s = 1; s <= 4; s++) sendTlp(0, s, 1, "p_grant");
        checkOutput("p_cc_hdr", int'(dut.cc_hdr[0]), 4);
        checkOutput("p_cc_data", int'(dut.cc_data[0]), 10);
        sendTlp(0, 5, 0, "p_deny_size5");
        checkOutput("p_cc_data_unchanged", int'(dut.cc_data[0]), 10);

        // UpdateFC raises the limit; a zero update changes nothing.
        applyStimulus(0, 1, 0, 10, 50, 0, 3, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 3, 0);
        checkOutput("upd_cl_hdr_p", int'(dut.cl_hdr[0]), 17);
        checkOutput("upd_cl_data_p", int'(dut.cl_data[0]), 60);
        sendTlp(0, 5, 1, "p_grant_after_upd");
        checkOutput("p_cc_data_15", int'(dut.cc_data[0]), 15);

        // Non-posted header exhaustion.
        for (int k = 1; k <= 10; k++) sendTlp(1, 0, (k <= 8), "np_hdr_limit");
        checkOutput("np_cc_hdr", int'(dut.cc_hdr[1]), 8);
        checkOutput("np_cc_data", int'(dut.cc_data[1]), 0);

        // Completion data exhaustion, then replenish.
        for (int s = 1; s <= 10; s++) sendTlp(2, s, (s <= 4), "cpl_data_limit");
        checkOutput("cpl_cc_data", int'(dut.cc_data[2]), 10);
        applyStimulus(0, 1, 2, 10, 50, 0, 3, 0);
        checkOutput("cpl_cl_hdr", int'(dut.cl_hdr[2]), 19);
        checkOutput("cpl_cl_data", int'(dut.cl_data[2]), 62);
        sendTlp(2, 5, 1, "cpl_grant_after_upd");

        // DLLP with class 11 changes nothing.
        applyStimulus(0, 1, 3, 5, 5, 0, 3, 0);
        checkOutput("none_dllp_cl_hdr_cpl", int'(dut.cl_hdr[2]), 19);

        // TLP class 11 is never granted.
        sendTlp(3, 1, 0, "type11_deny");

        // Held request is granted and charged on both cycles.
        sendTlp(0, 2, 1, "held_first");
        sendTlp(0, 2, 1, "held_second");
        checkOutput("held_cc_hdr", int'(dut.cc_hdr[0]), 7);
        checkOutput("held_cc_data", int'(dut.cc_data[0]), 19);

        // Same-class UpdateFC and consumption in one cycle.
        applyStimulus(0, 1, 0, 1, 1, 1, 0, 1);
        checkOutput("same_cycle_grant", int'(send_tlp_grant_o), 1);
        checkOutput("same_cycle_cl_data", int'(dut.cl_data[0]), 61);
        checkOutput("same_cycle_cc_data", int'(dut.cc_data[0]), 20);

        // InitFC wins over UpdateFC.
        applyStimulus(1, 1, 1, 20, 30, 0, 3, 0);
        checkOutput("init_wins_hdr", int'(dut.cl_hdr[1]), 20);
        checkOutput("init_wins_data", int'(dut.cl_data[1]), 30);

        // Reset in the middle of traffic clears everything.
        rst = 1'b1;
        applyStimulus(0, 0, 3, 0, 0, 1, 0, 1);
        rst = 1'b0;
        checkOutput("midreset_grant", int'(send_tlp_grant_o), 0);
        checkOutput("midreset_cl_data_p", int'(dut.cl_data[0]), 0);
        checkOutput("midreset_cc_hdr_np", int'(dut.cc_hdr[1]), 0);
        checkOutput("midreset_cl_hdr_cpl", int'(dut.cl_hdr[2]), 0);
        sendTlp(0, 0, 0, "post_reset_deny");

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
